// File: rtl/yuv_2xy_decimator_if.sv
// rtl/yuv_2xy_decimator_if.sv - stream bundle for the 2x2 YUV decimator
//
// Groups the 4-ppc input stream (rdata/rvalid/rreadsy/ruser/rlast) and the
// 1-ppc output stream (tdata/tvalid/treadsy/tuser/tlast).
//   master : the side that sources input beats and sinks output pixels
//   slave  : the decimator itself
// Pixels are {Y,U,V} with Y in the most significant component; input pixel k
// occupies rdata[k*3*data_width +: 3*data_width], pixel 0 leftmost.

interface yuv_2xy_decimator_if #(
    parameter int data_width        = 8,
    parameter int in_pix_per_clock  = 4,
    parameter int out_pix_per_clock = 1
);
    logic [in_pix_per_clock*3*data_width-1:0]  rdata;
    logic                                      rvalid;
    logic                                      rreadsy;
    logic                                      ruser;
    logic                                      rlast;
    logic [out_pix_per_clock*3*data_width-1:0] tdata;
    logic                                      tvalid;
    logic                                      treadsy;
    logic                                      tuser;
    logic                                      tlast;

    modport master (
        output rdata, rvalid, ruser, rlast, treadsy,
        input  rreadsy, tdata, tvalid, tuser, tlast
    );

    modport slave (
        input  rdata, rvalid, ruser, rlast, treadsy,
        output rreadsy, tdata, tvalid, tuser, tlast
    );
endinterface

// File: rtl/yuv_2xy_decimator.sv
// rtl/yuv_2xy_decimator.sv - 2:1 horizontal x 2:1 vertical YUV 4:4:4 downscaler
//
// Takes 4 pixels/beat, averages horizontal pairs into two output pixels and
// emits them one per clock. Vertically, even lines are kept and odd lines
// dropped, unless YUV_DECIM_BOX_FILTER_EN is defined, in which case even lines
// are stored as pair sums and averaged with the following odd line (2x2 box).
//
// Ports:
//   clk_in  - clock
//   reset   - synchronous active-low reset
//   bus     - yuv_2xy_decimator_if.slave: rdata/rvalid/rreadsy/ruser/rlast in,
//             tdata/tvalid/treadsy/tuser/tlast out
//
// Optional build macro: YUV_DECIM_BOX_FILTER_EN (2x2 box average).

module yuv_2xy_decimator #(
    parameter int data_width        = 8,
    parameter int in_pix_per_clock  = 4,
    parameter int out_pix_per_clock = 1,
    parameter int max_line_beats    = 480
) (
    input  logic                 clk_in,
    input  logic                 reset,
    yuv_2xy_decimator_if.slave   bus
);
    localparam int PIX_W = 3 * data_width;
    localparam int IN_W  = in_pix_per_clock * PIX_W;
    localparam int OUT_W = out_pix_per_clock * PIX_W;
    localparam int CNT_W = (max_line_beats > 1) ? $clog2(max_line_beats) : 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PIX0,
        S_PIX1
    } state_t;

    state_t             state_q, state_d;
    logic [PIX_W-1:0]   o0_q, o1_q;
    logic               first_q;
    logic               last_q;
    logic               parity_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sof_pend_q;

    logic [IN_W-1:0]    beat;
    logic [PIX_W-1:0]   p0, p1, p2, p3;
    logic [PIX_W-1:0]   new_o0, new_o1;
    logic               parity_eff;
    logic [CNT_W-1:0]   cnt_eff;
    logic               kept;
    logic               take;
    logic               rreadsy_c;
    logic               accept;
    logic               load;
    logic [OUT_W-1:0]   tdata_c;

    assign beat = bus.rdata;
    assign p0   = beat[0*PIX_W +: PIX_W];
    assign p1   = beat[1*PIX_W +: PIX_W];
    assign p2   = beat[2*PIX_W +: PIX_W];
    assign p3   = beat[3*PIX_W +: PIX_W];

    // ruser resynchronises: the beat carrying it is treated as the first beat
    // of an even line regardless of where the line was.
    assign parity_eff = bus.ruser ? 1'b0 : parity_q;
    assign cnt_eff    = bus.ruser ? '0 : cnt_q;

`ifdef YUV_DECIM_BOX_FILTER_EN
    localparam int SUM_W = 3 * (data_width + 1);

    logic [2*SUM_W-1:0] line_buf [max_line_beats];
    logic [2*SUM_W-1:0] buf_rd;

    function automatic logic [SUM_W-1:0] h_sum(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
        h_sum = '0;
        for (int c = 0; c < 3; c++) begin
            h_sum[c*(data_width+1) +: data_width+1] =
                {1'b0, a[c*data_width +: data_width]} +
                {1'b0, b[c*data_width +: data_width]};
        end
    endfunction

    function automatic logic [PIX_W-1:0] v_avg(input logic [SUM_W-1:0] e,
                                               input logic [SUM_W-1:0] o);
        logic [data_width+1:0] s;
        v_avg = '0;
        for (int c = 0; c < 3; c++) begin
            s = {1'b0, e[c*(data_width+1) +: data_width+1]} +
                {1'b0, o[c*(data_width+1) +: data_width+1]} +
                (data_width+2)'(2);
            v_avg[c*data_width +: data_width] = s[data_width+1:2];
        end
    endfunction

    // Odd lines carry output; even lines only fill the line buffer.
    assign kept   = parity_eff;
    assign buf_rd = line_buf[cnt_eff];
    assign new_o0 = v_avg(buf_rd[SUM_W-1:0],       h_sum(p0, p1));
    assign new_o1 = v_avg(buf_rd[2*SUM_W-1:SUM_W], h_sum(p2, p3));

    always_ff @(posedge clk_in) begin
        if (accept && !kept) begin
            line_buf[cnt_eff] <= {h_sum(p2, p3), h_sum(p0, p1)};
        end
    end
`else
    function automatic logic [PIX_W-1:0] h_avg(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
        logic [data_width:0] s;
        h_avg = '0;
        for (int c = 0; c < 3; c++) begin
            s = {1'b0, a[c*data_width +: data_width]} +
                {1'b0, b[c*data_width +: data_width]} +
                (data_width+1)'(1);
            h_avg[c*data_width +: data_width] = s[data_width:1];
        end
    endfunction

    assign kept   = !parity_eff;
    assign new_o0 = h_avg(p0, p1);
    assign new_o1 = h_avg(p2, p3);
`endif

    // A kept beat can enter only when the output pair registers are free or
    // are being vacated this cycle; a dropped beat never needs them.
    assign take      = (state_q == S_EMPTY) || (state_q == S_PIX1 && bus.treadsy);
    assign rreadsy_c = kept ? take : 1'b1;
    assign accept    = bus.rvalid && rreadsy_c;
    assign load      = accept && kept;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (load)        state_d = S_PIX0;
            S_PIX0:  if (bus.treadsy) state_d = S_PIX1;
            S_PIX1:  if (bus.treadsy) state_d = load ? S_PIX0 : S_EMPTY;
            default:                  state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        tdata_c = '0;
        case (state_q)
            S_PIX0:  tdata_c = OUT_W'(o0_q);
            S_PIX1:  tdata_c = OUT_W'(o1_q);
            default: tdata_c = '0;
        endcase
    end

    assign bus.rreadsy = rreadsy_c;
    assign bus.tvalid  = (state_q != S_EMPTY);
    assign bus.tdata   = tdata_c;
    assign bus.tuser   = (state_q == S_PIX0) && first_q;
    assign bus.tlast   = (state_q == S_PIX1) && last_q;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q    <= S_EMPTY;
            o0_q       <= '0;
            o1_q       <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            parity_q   <= 1'b0;
            cnt_q      <= '0;
            sof_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                o0_q    <= new_o0;
                o1_q    <= new_o1;
                first_q <= bus.ruser || sof_pend_q;
                last_q  <= bus.rlast;
            end
            if (accept) begin
                parity_q <= bus.rlast ? !parity_eff : parity_eff;
                if (bus.rlast || cnt_eff == CNT_W'(max_line_beats - 1)) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_eff + CNT_W'(1);
                end
                // Start-of-frame seen on a beat that produced no output is
                // carried to the first kept beat.
                if (load) begin
                    sof_pend_q <= 1'b0;
                end else if (bus.ruser) begin
                    sof_pend_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_yuv_2xy_decimator.sv
// tb/tb_yuv_2xy_decimator.sv - scoreboard bench for yuv_2xy_decimator

module tb_yuv_2xy_decimator;
    localparam int DW = 8;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } exp_t;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    logic        hold_valid = 1'b0;
    logic [31:0] hold_val   = '0;

    yuv_2xy_decimator_if #(.data_width(DW), .in_pix_per_clock(4), .out_pix_per_clock(1)) bus ();

    yuv_2xy_decimator #(
        .data_width(DW),
        .in_pix_per_clock(4),
        .out_pix_per_clock(1),
        .max_line_beats(480)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [23:0] px(input int y, input int u, input int v);
        return {y[7:0], u[7:0], v[7:0]};
    endfunction

    function automatic logic [23:0] px1(input int v);
        return px(v, v, v);
    endfunction

    function automatic logic [95:0] beat4(input logic [23:0] a, input logic [23:0] b,
                                          input logic [23:0] c, input logic [23:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [23:0] d, input logic u, input logic l);
        exp_t e;
        e.d = d;
        e.u = u;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic send_beat(input logic [95:0] d, input logic u, input logic l,
                             output int acc_cyc);
        int n;
        bit done;
        bus.rdata  = d;
        bus.ruser  = u;
        bus.rlast  = l;
        bus.rvalid = 1'b1;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk_in);
            if (bus.rreadsy) begin
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout actual=rreadsy_low required=accept");
                    done = 1;
                end
            end
        end
        @(posedge clk_in);
        acc_cyc = cyc;
        #1;
        bus.rvalid = 1'b0;
        bus.ruser  = 1'b0;
        bus.rlast  = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.tvalid) && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
        @(posedge clk_in);
        #1;
    endtask

    // Monitor: pops the scoreboard on each delivered pixel and checks that a
    // stalled output holds still.
    always @(negedge clk_in) begin
        exp_t e;
        if (reset) begin
            if (hold_valid) begin
                chk("hold_stable", {5'b0, bus.tvalid, bus.tuser, bus.tlast, bus.tdata}, hold_val);
            end
            if (bus.tvalid && bus.treadsy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", bus.tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tdata", {8'b0, bus.tdata}, {8'b0, e.d});
                    chk("out_tuser", {31'b0, bus.tuser}, {31'b0, e.u});
                    chk("out_tlast", {31'b0, bus.tlast}, {31'b0, e.l});
                end
            end
            hold_valid = bus.tvalid && !bus.treadsy;
            hold_val   = {5'b0, bus.tvalid, bus.tuser, bus.tlast, bus.tdata};
        end else begin
            hold_valid = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, a3;
        logic [95:0] bA, bB, bD, bE;

        bus.rdata   = beat4(px1(1), px1(2), px1(3), px1(4));
        bus.rvalid  = 1'b1;
        bus.ruser   = 1'b1;
        bus.rlast   = 1'b0;
        bus.treadsy = 1'b1;
        reset       = 1'b0;

        // Reset held with a valid beat pending
        repeat (10) begin
            @(negedge clk_in);
            chk("rst_tvalid", {31'b0, bus.tvalid}, 32'd0);
            chk("rst_tuser",  {31'b0, bus.tuser},  32'd0);
            chk("rst_tlast",  {31'b0, bus.tlast},  32'd0);
        end
        chk("rst_tdata", {8'b0, bus.tdata}, 32'd0);
        @(posedge clk_in);
        #1;
        bus.rvalid = 1'b0;
        bus.ruser  = 1'b0;
        reset      = 1'b1;
        repeat (5) begin
            @(negedge clk_in);
            chk("idle_after_rst", {31'b0, bus.tvalid}, 32'd0);
        end
        @(posedge clk_in);
        #1;

        // Horizontal average and rreadsy cadence 1,0,1,0
        bA = beat4(px(10, 0, 255), px(11, 1, 255), px(200, 2, 0), px(255, 3, 1));
        bB = beat4(px(0, 50, 7), px(0, 50, 8), px(1, 50, 9), px(2, 50, 9));
        push(px(11, 1, 255), 1'b1, 1'b0);
        push(px(228, 3, 1),  1'b0, 1'b0);
        push(px(0, 50, 8),   1'b0, 1'b0);
        push(px(2, 50, 9),   1'b0, 1'b0);
        bus.rdata  = bA;
        bus.ruser  = 1'b1;
        bus.rlast  = 1'b0;
        bus.rvalid = 1'b1;
        @(negedge clk_in);
        chk("hz_rreadsy_0", {31'b0, bus.rreadsy}, 32'd1);
        @(posedge clk_in);
        #1;
        bus.rdata = bB;
        bus.ruser = 1'b0;
        @(negedge clk_in);
        chk("hz_rreadsy_1", {31'b0, bus.rreadsy}, 32'd0);
        @(posedge clk_in);
        #1;
        @(negedge clk_in);
        chk("hz_rreadsy_2", {31'b0, bus.rreadsy}, 32'd1);
        @(posedge clk_in);
        #1;
        bus.rvalid = 1'b0;
        @(negedge clk_in);
        chk("hz_rreadsy_3", {31'b0, bus.rreadsy}, 32'd0);
        wait_empty();

        // Two-line frame, 2 beats per line; second line dropped
        push(px1(21), 1'b1, 1'b0);
        push(px1(41), 1'b0, 1'b0);
        push(px1(2),  1'b0, 1'b0);
        push(px1(4),  1'b0, 1'b1);
        send_beat(beat4(px1(20), px1(22), px1(40), px1(41)), 1'b1, 1'b0, a0);
        send_beat(beat4(px1(1), px1(2), px1(3), px1(4)), 1'b0, 1'b1, a1);
        send_beat(beat4(px1(99), px1(98), px1(97), px1(96)), 1'b0, 1'b0, a2);
        send_beat(beat4(px1(90), px1(91), px1(92), px1(93)), 1'b0, 1'b1, a3);
        chk("drop_line_consecutive", a3 - a2, 32'd1);
        chk("drop_line_no_wait", a2 - a1, 32'd1);
        wait_empty();

        // Backpressure in S_PIX0 for 5 cycles
        bD = beat4(px1(3), px1(5), px1(7), px1(9));
        bE = beat4(px1(0), px1(255), px1(255), px1(255));
        push(px1(4),   1'b0, 1'b0);
        push(px1(8),   1'b0, 1'b0);
        push(px1(128), 1'b0, 1'b0);
        push(px1(255), 1'b0, 1'b0);
        bus.treadsy = 1'b0;
        send_beat(bD, 1'b0, 1'b0, a0);
        bus.rdata  = bE;
        bus.rvalid = 1'b1;
        repeat (5) begin
            @(negedge clk_in);
            chk("bp_rreadsy", {31'b0, bus.rreadsy}, 32'd0);
            chk("bp_tvalid",  {31'b0, bus.tvalid},  32'd1);
            chk("bp_tdata",   {8'b0, bus.tdata},    {8'b0, px1(4)});
            @(posedge clk_in);
            #1;
        end
        bus.treadsy = 1'b1;
        send_beat(bE, 1'b0, 1'b0, a1);
        wait_empty();

        // Resync: ruser on beat 1 of a dropped line
        push(px1(10),  1'b1, 1'b0);
        push(px1(10),  1'b0, 1'b1);
        push(px1(61),  1'b1, 1'b0);
        push(px1(102), 1'b0, 1'b0);
        send_beat(beat4(px1(10), px1(10), px1(10), px1(10)), 1'b1, 1'b1, a0);
        send_beat(beat4(px1(7), px1(7), px1(7), px1(7)), 1'b0, 1'b0, a1);
        send_beat(beat4(px1(60), px1(62), px1(100), px1(104)), 1'b1, 1'b0, a2);
        wait_empty();

        // Reset mid-operation discards held pixels
        bus.treadsy = 1'b0;
        send_beat(beat4(px1(33), px1(33), px1(33), px1(33)), 1'b0, 1'b0, a0);
        reset = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset       = 1'b1;
        bus.treadsy = 1'b1;
        repeat (5) begin
            @(negedge clk_in);
            chk("midrst_idle", {31'b0, bus.tvalid}, 32'd0);
        end
        @(posedge clk_in);
        #1;
        push(px1(1), 1'b0, 1'b0);
        push(px1(1), 1'b0, 1'b1);
        send_beat(beat4(px1(1), px1(1), px1(1), px1(1)), 1'b0, 1'b1, a0);
        wait_empty();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
